// File: rtl/axis_stall_pkg.sv
// axis_stall_pkg
//   Shared types and codes for the AXI-Stream stall detector.
//   stall_state_t : per-channel FSM state
//   INFO_*        : two-bit stall classification reported on axis_block_info
//   classify()    : maps a tvalid/tready pair onto a stall kind (transfer and
//                   quiet cycles both map to INFO_NONE)
package axis_stall_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BLOCKED = 2'd2
  } stall_state_t;

  localparam logic [1:0] INFO_NONE   = 2'b00;
  localparam logic [1:0] INFO_STARVE = 2'b01;
  localparam logic [1:0] INFO_BP     = 2'b10;

  function automatic logic [1:0] classify(input logic tvalid, input logic tready);
    if (!tvalid && tready) begin
      return INFO_STARVE;
    end else if (tvalid && !tready) begin
      return INFO_BP;
    end else begin
      return INFO_NONE;
    end
  endfunction

endpackage

// File: rtl/axis_stall_channel.sv
// axis_stall_channel
//   One channel of the stall detector: classifies the tvalid/tready tap every
//   cycle and runs a small FSM with a saturating run-length counter. The
//   channel is flagged blocked once the same stall kind has been seen on
//   THRESH consecutive edges.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no stall in progress, counter 0
//   ST_WAIT    | stall of kind kind_q seen on cnt_q consecutive edges
//   ST_BLOCKED | stall persisted THRESH edges; sig/info asserted
//
// Ports
//   clock, reset   clock and synchronous active-high reset
//   qual           channel qualified (enable, not idle, not masked)
//   tvalid, tready AXIS handshake tap
//   block_nxt      next-state blocked flag (feeds the registered OR at top)
//   block_sig      registered blocked flag
//   block_info     registered stall kind, nonzero only while blocked
module axis_stall_channel
  import axis_stall_pkg::*;
#(
  parameter int THRESH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qual,
  input  logic       tvalid,
  input  logic       tready,
  output logic       block_nxt,
  output logic       block_sig,
  output logic [1:0] block_info
);

  localparam int CW = $clog2(THRESH + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(THRESH);

  stall_state_t   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     kind_q, kind_d;
  logic           sig_q, sig_d;
  logic [1:0]     info_q, info_d;

  logic [1:0]     kind_now;
  logic           stall;
  logic           restart;

  assign kind_now = classify(tvalid, tready);
  assign stall    = qual && (kind_now != INFO_NONE);
  // A fresh stall run starts from IDLE or whenever the kind flips
  // between starved and back-pressured.
  assign restart  = (state_q == ST_IDLE) || (kind_now != kind_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    if (!stall) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      kind_d  = INFO_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT, ST_BLOCKED: begin
          if (restart) begin
            kind_d  = kind_now;
            cnt_d   = CNT_ONE;
            // THRESH==1 blocks on the very first stalled edge.
            state_d = (CNT_ONE == CNT_MAX) ? ST_BLOCKED : ST_WAIT;
          end else if (state_q == ST_WAIT) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            state_d = (cnt_d == CNT_MAX) ? ST_BLOCKED : ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          kind_d  = INFO_NONE;
        end
      endcase
    end
    sig_d  = (state_d == ST_BLOCKED);
    info_d = sig_d ? kind_d : INFO_NONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kind_q  <= INFO_NONE;
      sig_q   <= 1'b0;
      info_q  <= INFO_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      sig_q   <= sig_d;
      info_q  <= info_d;
    end
  end

  assign block_nxt  = sig_d;
  assign block_sig  = sig_q;
  assign block_info = info_q;

endmodule

// File: rtl/axis_stall_detector.sv
// axis_stall_detector
//   Per-channel AXI-Stream stall detector. Taps tvalid/tready of each AXIS
//   port, flags channels that stay starved or back-pressured for THRESH
//   consecutive cycles, and drives the registered block-signal vectors read
//   by the deadlock monitor.
//
// Build option
//   AXIS_STALL_LATCH_EN : adds first_blk_vld/idx/cyc, a sticky record of the
//                         lowest channel and cycle number of the first block.
//
// Ports
//   clock, reset     clock and synchronous active-high reset
//   enable           detection window; low clears every channel
//   inst_idle[i]     owning instance idle; clears channel i
//   tvalid, tready   AXIS taps, N_CH each
//   axis_block_sigs  channel i blocked
//   axis_block_info  [2i+1:2i] 01 starved, 10 back-pressured, 00 none
//   any_block        registered OR of the blocked flags
//   first_blk_*      (AXIS_STALL_LATCH_EN only) first-block capture
module axis_stall_detector
  import axis_stall_pkg::*;
#(
  parameter int              N_CH    = 4,
  parameter int              THRESH  = 16,
  parameter logic [N_CH-1:0] CH_MASK = {N_CH{1'b1}},
  localparam int             IW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   inst_idle,
  input  logic [N_CH-1:0]   tvalid,
  input  logic [N_CH-1:0]   tready,
  output logic [N_CH-1:0]   axis_block_sigs,
  output logic [2*N_CH-1:0] axis_block_info,
`ifdef AXIS_STALL_LATCH_EN
  output logic              first_blk_vld,
  output logic [IW-1:0]     first_blk_idx,
  output logic [31:0]       first_blk_cyc,
`endif
  output logic              any_block
);

  logic [N_CH-1:0] qual;
  logic [N_CH-1:0] blk_nxt;
  logic            any_block_q, any_block_d;

  // Masked channels are held permanently unqualified, so they sit in IDLE
  // with all outputs low.
  assign qual = {N_CH{enable}} & ~inst_idle & CH_MASK;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    axis_stall_channel #(
      .THRESH (THRESH)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .qual       (qual[i]),
      .tvalid     (tvalid[i]),
      .tready     (tready[i]),
      .block_nxt  (blk_nxt[i]),
      .block_sig  (axis_block_sigs[i]),
      .block_info (axis_block_info[2*i +: 2])
    );
  end

  // Built from next-state flags so the register lands on the same edge as
  // the per-channel sigs.
  assign any_block_d = |blk_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      any_block_q <= 1'b0;
    end else begin
      any_block_q <= any_block_d;
    end
  end

  assign any_block = any_block_q;

`ifdef AXIS_STALL_LATCH_EN
  logic            vld_q, vld_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     fcyc_q, fcyc_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [IW-1:0]   low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (blk_nxt[i]) begin
        low_idx = IW'(i);
      end
    end
  end

  // cyc_d is the number of the edge being evaluated, counted from the first
  // edge after reset is released.
  always_comb begin
    cyc_d  = cyc_q + 32'd1;
    vld_d  = vld_q;
    idx_d  = idx_q;
    fcyc_d = fcyc_q;
    if (!vld_q && any_block_d && !any_block_q) begin
      vld_d  = 1'b1;
      idx_d  = low_idx;
      fcyc_d = cyc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q  <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      fcyc_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      fcyc_q <= fcyc_d;
    end
  end

  assign first_blk_vld = vld_q;
  assign first_blk_idx = idx_q;
  assign first_blk_cyc = fcyc_q;
`endif

endmodule

// File: tb/tb_axis_stall_detector.sv
// tb_axis_stall_detector
//   Directed bench for axis_stall_detector. Three instances share the stimulus:
//   dut (THRESH=4, all channels), dut_m (THRESH=4, CH_MASK=4'h7) and
//   dut_t1 (THRESH=1). Inputs change after the falling edge; outputs are
//   checked after the following falling edge.
module tb_axis_stall_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] inst_idle;
  logic [3:0] tvalid;
  logic [3:0] tready;

  logic [3:0] sigs,   sigs_m,   sigs_1;
  logic [7:0] info,   info_m,   info_1;
  logic       anyb,   any_m,    any_1;

`ifdef AXIS_STALL_LATCH_EN
  logic        fb_vld,   fb_vld_m,   fb_vld_1;
  logic [1:0]  fb_idx,   fb_idx_m,   fb_idx_1;
  logic [31:0] fb_cyc,   fb_cyc_m,   fb_cyc_1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  axis_stall_detector #(.N_CH(4), .THRESH(4), .CH_MASK(4'hF)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .inst_idle       (inst_idle),
    .tvalid          (tvalid),
    .tready          (tready),
    .axis_block_sigs (sigs),
    .axis_block_info (info),
`ifdef AXIS_STALL_LATCH_EN
    .first_blk_vld   (fb_vld),
    .first_blk_idx   (fb_idx),
    .first_blk_cyc   (fb_cyc),
`endif
    .any_block       (anyb)
  );

  axis_stall_detector #(.N_CH(4), .THRESH(4), .CH_MASK(4'h7)) dut_m (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .inst_idle       (inst_idle),
    .tvalid          (tvalid),
    .tready          (tready),
    .axis_block_sigs (sigs_m),
    .axis_block_info (info_m),
`ifdef AXIS_STALL_LATCH_EN
    .first_blk_vld   (fb_vld_m),
    .first_blk_idx   (fb_idx_m),
    .first_blk_cyc   (fb_cyc_m),
`endif
    .any_block       (any_m)
  );

  axis_stall_detector #(.N_CH(4), .THRESH(1), .CH_MASK(4'hF)) dut_t1 (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .inst_idle       (inst_idle),
    .tvalid          (tvalid),
    .tready          (tready),
    .axis_block_sigs (sigs_1),
    .axis_block_info (info_1),
`ifdef AXIS_STALL_LATCH_EN
    .first_blk_vld   (fb_vld_1),
    .first_blk_idx   (fb_idx_1),
    .first_blk_cyc   (fb_cyc_1),
`endif
    .any_block       (any_1)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with unknown inputs
    reset     = 1'b1;
    enable    = 1'bx;
    inst_idle = 'x;
    tvalid    = 'x;
    tready    = 'x;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sigs", {28'd0, sigs}, 32'h0);
      chk("rst_info", {24'd0, info}, 32'h0);
      chk("rst_any",  {31'd0, anyb}, 32'h0);
      chk("rst_t1",   {28'd0, sigs_1}, 32'h0);
    end
    enable    = 1'b0;
    inst_idle = 4'h0;
    tvalid    = 4'h0;
    tready    = 4'h0;
    tick();
    reset = 1'b0;
    tick();
    chk("idle_sigs", {28'd0, sigs}, 32'h0);

    // 2: ch0 starved
    enable = 1'b1;
    tready = 4'b0001;
    tick();
    chk("t1_starve_blk", {28'd0, sigs_1}, 32'h1);
    chk("t1_starve_any", {31'd0, any_1}, 32'h1);
    chk("starve_e1", {28'd0, sigs}, 32'h0);
    tick();
    chk("starve_e2", {28'd0, sigs}, 32'h0);
    tick();
    chk("starve_e3", {28'd0, sigs}, 32'h0);
    chk("starve_e3_any", {31'd0, anyb}, 32'h0);
    tick();
    chk("starve_e4_sigs", {28'd0, sigs}, 32'h1);
    chk("starve_e4_info", {24'd0, info}, 32'h01);
    chk("starve_e4_any",  {31'd0, anyb}, 32'h1);
    tick();
    chk("starve_e5_hold", {28'd0, sigs}, 32'h1);
    tvalid = 4'b0001;
    tick();
    chk("xfer_e6_sigs", {28'd0, sigs}, 32'h0);
    chk("xfer_e6_info", {24'd0, info}, 32'h0);
    chk("xfer_e6_any",  {31'd0, anyb}, 32'h0);
    chk("xfer_e6_t1",   {28'd0, sigs_1}, 32'h0);
    tvalid = 4'h0;
    tready = 4'h0;
    tick();

    // 3: ch2 back-pressured, broken by one transfer
    tvalid = 4'b0100;
    tready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pre", {28'd0, sigs}, 32'h0);
    end
    tready = 4'b0100;
    tick();
    chk("bp_xfer", {28'd0, sigs}, 32'h0);
    tready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_post", {28'd0, sigs}, 32'h0);
    end
    tick();
    chk("bp_sigs", {28'd0, sigs}, 32'h4);
    chk("bp_info", {24'd0, info}, 32'h20);
    chk("bp_any",  {31'd0, anyb}, 32'h1);
    tvalid = 4'h0;
    tick();
    chk("bp_none_rel", {28'd0, sigs}, 32'h0);

    // 4: ch1 starve -> back-pressure restarts the run
    tready = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("kind_starve", {28'd0, sigs}, 32'h0);
    end
    chk("t1_kind_starve_info", {24'd0, info_1}, 32'h04);
    tvalid = 4'b0010;
    tready = 4'b0000;
    tick();
    chk("t1_kind_bp_info", {24'd0, info_1}, 32'h08);
    chk("t1_kind_bp_sigs", {28'd0, sigs_1}, 32'h2);
    chk("kind_bp1", {28'd0, sigs}, 32'h0);
    tick();
    tick();
    chk("kind_bp3", {28'd0, sigs}, 32'h0);
    tick();
    chk("kind_bp4_sigs", {28'd0, sigs}, 32'h2);
    chk("kind_bp4_info", {24'd0, info}, 32'h08);
    tvalid = 4'h0;
    tick();

    // 5a: ch3 stalled while its instance is idle
    tready    = 4'b1000;
    inst_idle = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_gate", {28'd0, sigs}, 32'h0);
    end
    // 5b: ch3 qualified: blocks in dut, never in the masked instance
    inst_idle = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    chk("mask_dut_sigs", {28'd0, sigs},   32'h8);
    chk("mask_dut_info", {24'd0, info},   32'h40);
    chk("mask_m_sigs",   {28'd0, sigs_m}, 32'h0);
    chk("mask_m_info",   {24'd0, info_m}, 32'h0);
    chk("mask_m_any",    {31'd0, any_m},  32'h0);
    inst_idle = 4'b1000;
    tick();
    chk("idle_drop", {28'd0, sigs}, 32'h0);
    inst_idle = 4'b0000;
    tready    = 4'b0000;
    tick();

    // 5c: enable drop while ch0 blocked, then counters restart
    tready = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    chk("en_blk", {28'd0, sigs}, 32'h1);
    enable = 1'b0;
    tick();
    chk("en_drop_sigs", {28'd0, sigs}, 32'h0);
    chk("en_drop_info", {24'd0, info}, 32'h0);
    chk("en_drop_any",  {31'd0, anyb}, 32'h0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("en_restart3", {28'd0, sigs}, 32'h0);
    tick();
    chk("en_restart4", {28'd0, sigs}, 32'h1);
    // reset wins over a persisting stall
    reset = 1'b1;
    tick();
    chk("rst_mid_sigs", {28'd0, sigs}, 32'h0);
    chk("rst_mid_any",  {31'd0, anyb}, 32'h0);
    reset  = 1'b0;
    tready = 4'b0000;
    tick();

`ifdef AXIS_STALL_LATCH_EN
    // 6: first-block capture, ch1 and ch3 tie on edge 20
    reset = 1'b1;
    tick();
    chk("latch_rst_vld", {31'd0, fb_vld}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    tready = 4'b1010;
    for (int i = 0; i < 3; i++) tick();
    chk("latch_pre_vld", {31'd0, fb_vld}, 32'h0);
    tick();
    chk("latch_sigs", {28'd0, sigs},   32'ha);
    chk("latch_vld",  {31'd0, fb_vld}, 32'h1);
    chk("latch_idx",  {30'd0, fb_idx}, 32'h1);
    chk("latch_cyc",  fb_cyc,          32'd20);
    tready = 4'b1011;
    for (int i = 0; i < 4; i++) tick();
    chk("latch_later_sigs", {28'd0, sigs},   32'hb);
    chk("latch_later_idx",  {30'd0, fb_idx}, 32'h1);
    chk("latch_later_cyc",  fb_cyc,          32'd20);
    enable = 1'b0;
    tick();
    chk("latch_en_vld", {31'd0, fb_vld}, 32'h1);
    chk("latch_en_cyc", fb_cyc,          32'd20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
